// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: controller states,
// default counter widths and the core's opcode map.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam int SC_W_DEF = 16;
    localparam int FC_W_DEF = 8;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_HALT   = 7'b1110011;

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline enable/flush/bubble responder for the 5-stage core,
// with sticky halt/stall-error status and saturating counters.
module hazard_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int MAX_STALL    = 3,
    parameter int SC_W         = SC_W_DEF,
    parameter int FC_W         = FC_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_req,
    input  logic            branch_taken,
    input  logic            mem_busy,
    input  logic            halt_req,
    output logic            pc_en,
    output logic            pc_sel_branch,
    output logic            ifid_en,
    output logic            ifid_flush,
    output logic            idex_bubble,
    output logic            exmem_en,
    output logic            memwb_en,
    output logic            forward_en,
    output logic            halted,
    output logic            err_stall,
    output logic [SC_W-1:0] stall_cycles,
    output logic [FC_W-1:0] flush_count
);

    localparam logic [4:0] RUN_ERR = 5'(MAX_STALL);
    localparam logic [2:0] FL_LOAD = 3'(FLUSH_CYCLES - 1);

    state_t     state, state_nx;
    logic [2:0] fl_cnt, fl_cnt_nx;
    logic [4:0] run_cnt;
    logic       sc_inc, fc_inc, stall_hit;

    always_comb begin
        pc_en         = 1'b1;
        pc_sel_branch = 1'b0;
        ifid_en       = 1'b1;
        ifid_flush    = 1'b0;
        idex_bubble   = 1'b0;
        exmem_en      = 1'b1;
        memwb_en      = 1'b1;
        state_nx      = state;
        fl_cnt_nx     = fl_cnt;
        sc_inc        = 1'b0;
        fc_inc        = 1'b0;
        stall_hit     = 1'b0;
        if (rst) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else begin
            unique case (state)
                RUN, FLUSH: begin
                    if (mem_busy) begin
                        pc_en    = 1'b0;
                        ifid_en  = 1'b0;
                        exmem_en = 1'b0;
                        memwb_en = 1'b0;
                        sc_inc   = 1'b1;
                    end else if (halt_req) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_bubble = 1'b1;
                        state_nx    = HALT;
                    end else if (state == FLUSH) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                        fl_cnt_nx   = fl_cnt - 3'd1;
                        if (fl_cnt <= 3'd1) begin
                            state_nx = RUN;
                        end
                    end else if (branch_taken) begin
                        pc_sel_branch = 1'b1;
                        ifid_flush    = 1'b1;
                        idex_bubble   = 1'b1;
                        fc_inc        = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_nx  = FLUSH;
                            fl_cnt_nx = FL_LOAD;
                        end
                    end else if (stall_req) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_bubble = 1'b1;
                        sc_inc      = 1'b1;
                        stall_hit   = 1'b1;
                    end
                end
                HALT: begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_bubble = 1'b1;
                    exmem_en    = !mem_busy;
                    memwb_en    = !mem_busy;
                end
                default: state_nx = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            fl_cnt     <= '0;
            run_cnt    <= '0;
            forward_en <= 1'b0;
            err_stall  <= 1'b0;
        end else begin
            state      <= state_nx;
            fl_cnt     <= fl_cnt_nx;
            forward_en <= 1'b1;
            // Run length only grows on stalls that actually took effect.
            if (!stall_req) begin
                run_cnt <= '0;
            end else if (stall_hit && (run_cnt <= RUN_ERR)) begin
                run_cnt <= run_cnt + 5'd1;
            end
            if (stall_hit && (run_cnt == RUN_ERR)) begin
                err_stall <= 1'b1;
            end
        end
    end

    assign halted = (state == HALT);

    sat_counter #(.W(SC_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (sc_inc),
        .count (stall_cycles)
    );

    sat_counter #(.W(FC_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (fc_inc),
        .count (flush_count)
    );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Table, directed and random checks of hazard_stall_ctrl
// against a cycle-level reference model of the pipeline rules.
module tb_hazard_stall_ctrl;

    localparam int FC = 3;
    localparam int MS = 3;

    logic        clk;
    logic        rst, stall_req, branch_taken, mem_busy, halt_req;
    logic        pc_en, pc_sel_branch, ifid_en, ifid_flush, idex_bubble;
    logic        exmem_en, memwb_en, forward_en, halted, err_stall;
    logic [15:0] stall_cycles;
    logic [7:0]  flush_count;

    hazard_stall_ctrl #(
        .FLUSH_CYCLES (FC),
        .MAX_STALL    (MS),
        .SC_W         (16),
        .FC_W         (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_req     (stall_req),
        .branch_taken  (branch_taken),
        .mem_busy      (mem_busy),
        .halt_req      (halt_req),
        .pc_en         (pc_en),
        .pc_sel_branch (pc_sel_branch),
        .ifid_en       (ifid_en),
        .ifid_flush    (ifid_flush),
        .idex_bubble   (idex_bubble),
        .exmem_en      (exmem_en),
        .memwb_en      (memwb_en),
        .forward_en    (forward_en),
        .halted        (halted),
        .err_stall     (err_stall),
        .stall_cycles  (stall_cycles),
        .flush_count   (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_en, pc_sel, ifid_en, ifid_flush, idex_bubble, exmem_en, memwb_en}
    localparam logic [6:0] O_RST  = 7'b0001100;
    localparam logic [6:0] O_NORM = 7'b1010011;
    localparam logic [6:0] O_BUSY = 7'b0000000;
    localparam logic [6:0] O_HOLD = 7'b0000111;
    localparam logic [6:0] O_BR   = 7'b1111111;
    localparam logic [6:0] O_FL   = 7'b1011111;
    localparam logic [6:0] O_HBSY = 7'b0000100;

    typedef struct {
        logic       rst, stall, br, busy, halt;
        logic [6:0] o;
        logic       fwd, err, hlt;
        int         sc, fc;
    } vec_t;

    vec_t vt[27];
    int   n_chk = 0;
    int   n_fail = 0;

    int m_mode, m_left, m_run, m_sc, m_fc;
    bit m_fwd, m_err;

    function automatic vec_t mk(logic r, logic s, logic b, logic m,
                                logic h, logic [6:0] o, logic f,
                                logic e, logic hl, int sc, int fc);
        vec_t v;
        v.rst = r; v.stall = s; v.br = b; v.busy = m; v.halt = h;
        v.o = o; v.fwd = f; v.err = e; v.hlt = hl; v.sc = sc; v.fc = fc;
        return v;
    endfunction

    function automatic logic [6:0] dut_o();
        return {pc_en, pc_sel_branch, ifid_en, ifid_flush,
                idex_bubble, exmem_en, memwb_en};
    endfunction

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_mode = 0; m_left = 0; m_run = 0;
        m_sc = 0; m_fc = 0; m_fwd = 0; m_err = 0;
    endtask

    // Mode 0 = running, 1 = flushing after a branch, 2 = halted.
    function automatic logic [6:0] m_out();
        if (rst) return O_RST;
        if (m_mode == 2) return mem_busy ? O_HBSY : O_HOLD;
        if (mem_busy) return O_BUSY;
        if (halt_req) return O_HOLD;
        if (m_mode == 1) return O_FL;
        if (branch_taken) return O_BR;
        if (stall_req) return O_HOLD;
        return O_NORM;
    endfunction

    task automatic m_edge();
        if (rst) begin
            m_reset();
            return;
        end
        m_fwd = 1;
        if (m_mode != 2) begin
            if (mem_busy) begin
                if (m_sc < 65535) m_sc++;
            end else if (halt_req) begin
                m_mode = 2;
            end else if (m_mode == 1) begin
                m_left--;
                if (m_left == 0) m_mode = 0;
            end else if (branch_taken) begin
                if (m_fc < 255) m_fc++;
                if (FC > 1) begin
                    m_mode = 1;
                    m_left = FC - 1;
                end
            end else if (stall_req) begin
                if (m_sc < 65535) m_sc++;
                m_run++;
                if (m_run == MS + 1) m_err = 1;
            end
        end
        if (!stall_req) m_run = 0;
    endtask

    task automatic chk_model(string tag);
        chk({tag, ".outs"}, int'(dut_o()), int'(m_out()));
        chk({tag, ".halted"}, int'(halted), (m_mode == 2) ? 1 : 0);
        chk({tag, ".fwd"}, int'(forward_en), int'(m_fwd));
        chk({tag, ".err"}, int'(err_stall), int'(m_err));
        chk({tag, ".sc"}, int'(stall_cycles), m_sc);
        chk({tag, ".fc"}, int'(flush_count), m_fc);
    endtask

    task automatic cycle(logic r, logic s, logic b, logic m, logic h,
                         bit do_chk, string tag);
        @(negedge clk);
        rst = r; stall_req = s; branch_taken = b;
        mem_busy = m; halt_req = h;
        #1;
        if (rst) m_reset();
        if (do_chk) chk_model(tag);
        @(posedge clk);
        m_edge();
    endtask

    initial begin
        rst = 1'b1; stall_req = 1'b0; branch_taken = 1'b0;
        mem_busy = 1'b0; halt_req = 1'b0;
        m_reset();

        //         rst s  b  m  h  outs    fwd err hlt sc fc
        vt[0]  = mk(1, 0, 0, 0, 0, O_RST,  0, 0, 0, 0, 0);
        vt[1]  = mk(1, 0, 0, 0, 0, O_RST,  0, 0, 0, 0, 0);
        vt[2]  = mk(0, 0, 0, 0, 0, O_NORM, 0, 0, 0, 0, 0);
        vt[3]  = mk(0, 0, 0, 0, 0, O_NORM, 1, 0, 0, 0, 0);
        vt[4]  = mk(0, 1, 0, 0, 0, O_HOLD, 1, 0, 0, 0, 0);
        vt[5]  = mk(0, 1, 0, 0, 0, O_HOLD, 1, 0, 0, 1, 0);
        vt[6]  = mk(0, 0, 0, 0, 0, O_NORM, 1, 0, 0, 2, 0);
        vt[7]  = mk(0, 1, 0, 0, 0, O_HOLD, 1, 0, 0, 2, 0);
        vt[8]  = mk(0, 1, 0, 0, 0, O_HOLD, 1, 0, 0, 3, 0);
        vt[9]  = mk(0, 1, 0, 0, 0, O_HOLD, 1, 0, 0, 4, 0);
        vt[10] = mk(0, 1, 0, 0, 0, O_HOLD, 1, 0, 0, 5, 0);
        vt[11] = mk(0, 0, 0, 0, 0, O_NORM, 1, 1, 0, 6, 0);
        vt[12] = mk(0, 1, 1, 0, 0, O_BR,   1, 1, 0, 6, 0);
        vt[13] = mk(0, 1, 0, 0, 0, O_FL,   1, 1, 0, 6, 1);
        vt[14] = mk(0, 0, 1, 0, 0, O_FL,   1, 1, 0, 6, 1);
        vt[15] = mk(0, 0, 0, 0, 0, O_NORM, 1, 1, 0, 6, 1);
        vt[16] = mk(0, 0, 1, 0, 0, O_BR,   1, 1, 0, 6, 1);
        vt[17] = mk(0, 0, 0, 0, 0, O_FL,   1, 1, 0, 6, 2);
        vt[18] = mk(0, 0, 0, 1, 0, O_BUSY, 1, 1, 0, 6, 2);
        vt[19] = mk(0, 0, 1, 1, 0, O_BUSY, 1, 1, 0, 7, 2);
        vt[20] = mk(0, 1, 0, 1, 0, O_BUSY, 1, 1, 0, 8, 2);
        vt[21] = mk(0, 0, 0, 0, 0, O_FL,   1, 1, 0, 9, 2);
        vt[22] = mk(0, 0, 0, 0, 0, O_NORM, 1, 1, 0, 9, 2);
        vt[23] = mk(0, 0, 0, 0, 1, O_HOLD, 1, 1, 0, 9, 2);
        vt[24] = mk(0, 1, 1, 0, 0, O_HOLD, 1, 1, 1, 9, 2);
        vt[25] = mk(0, 0, 0, 1, 0, O_HBSY, 1, 1, 1, 9, 2);
        vt[26] = mk(1, 0, 0, 0, 0, O_RST,  0, 0, 0, 0, 0);

        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            rst = vt[i].rst; stall_req = vt[i].stall;
            branch_taken = vt[i].br; mem_busy = vt[i].busy;
            halt_req = vt[i].halt;
            #1;
            if (rst) m_reset();
            chk($sformatf("vec%0d.outs", i), int'(dut_o()), int'(vt[i].o));
            chk($sformatf("vec%0d.fwd", i), int'(forward_en), int'(vt[i].fwd));
            chk($sformatf("vec%0d.err", i), int'(err_stall), int'(vt[i].err));
            chk($sformatf("vec%0d.halted", i), int'(halted), int'(vt[i].hlt));
            chk($sformatf("vec%0d.sc", i), int'(stall_cycles), vt[i].sc);
            chk($sformatf("vec%0d.fc", i), int'(flush_count), vt[i].fc);
            chk_model($sformatf("vec%0d.model", i));
            @(posedge clk);
            m_edge();
        end

        cycle(1, 0, 0, 0, 0, 1, "rnd_rst");
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 59) == 0),
                  1, $sformatf("rnd%0d", i));
        end

        cycle(1, 0, 0, 0, 0, 1, "fsat_rst");
        for (int i = 0; i < 900; i++) begin
            cycle(0, 0, 1, 0, 0, (i % 100 == 0), "fsat");
        end
        cycle(0, 0, 0, 0, 0, 1, "fsat_end");
        chk("fc_saturated", int'(flush_count), 255);

        cycle(1, 0, 0, 0, 0, 1, "ssat_rst");
        for (int i = 0; i < 70000; i++) begin
            cycle(0, 1, 0, 0, 0, (i % 5000 == 0), "ssat");
        end
        cycle(0, 1, 0, 0, 0, 1, "ssat_end");
        chk("sc_saturated", int'(stall_cycles), 65535);
        chk("sc_sat_err", int'(err_stall), 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
